// File: rtl/fp32_accum.sv
// -----------------------------------------------------------------------------
// fp32_accum
//
// Sequential IEEE-754 single-precision accumulator. It consumes a stream of
// FP32 addends over a valid/ready handshake and sums them with a four-cycle
// IDLE -> ALIGN -> ADD -> NORM sequence. When the element tagged last has been
// added, the sum is presented on the output handshake.
//
// Denormal inputs are flushed to zero, and results that underflow are flushed
// to a signed zero. Any NaN input, or the sum of two opposite infinities,
// makes the accumulator the quiet NaN 0x7FC00000 until the result is consumed.
//
// Build option:
//   FP32_ACC_ROUND_EN  defined   : round-to-nearest-even on guard/round/sticky
//                      undefined : truncation (round toward zero)
//
// Parameters:
//   CNT_W      width of the saturating element counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_last valid
//   in_ready   block can accept an element (IDLE and not in reset)
//   in_data    FP32 addend
//   in_last    marks the final element of the current sum
//   out_valid  result valid (OUT state)
//   out_ready  downstream accepts the result
//   out_data   accumulated FP32 sum
//   out_cnt    number of elements in this sum, saturating at all-ones
//   out_ovf    sum overflowed to infinity from finite operands
//   out_nan    result is NaN
// -----------------------------------------------------------------------------
module fp32_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_nan
);

`ifdef FP32_ACC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // How NORM produces the new accumulator value.
    localparam logic [1:0] SP_NONE = 2'd0;  // ordinary finite add
    localparam logic [1:0] SP_NAN  = 2'd1;  // result forced to quiet NaN
    localparam logic [1:0] SP_PASS = 2'd2;  // result is an infinite operand

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_nan;
    logic [31:0]      r_op;
    logic             r_last;

    // ALIGN -> ADD
    logic             r_sign;       // sign of the larger magnitude
    logic             r_sub;        // operand signs differ
    logic [7:0]       r_exp;        // exponent of the larger magnitude
    logic [26:0]      r_big;        // {hidden, frac, g, r, s}
    logic [26:0]      r_small;      // aligned smaller significand
    logic [1:0]       r_spec;
    logic [31:0]      r_spec_val;

    // ADD -> NORM
    logic [27:0]      r_sum;

    // ------------------------------------------------------------------------
    // ALIGN: unpack, order by magnitude, shift the smaller operand
    // ------------------------------------------------------------------------
    logic        w_a_zero, w_b_zero;
    logic        w_a_inf,  w_b_inf;
    logic        w_a_nan,  w_b_nan;
    logic [30:0] w_a_mag,  w_b_mag;
    logic [26:0] w_a_sig,  w_b_sig;
    logic        w_a_ge;
    logic [7:0]  w_big_exp, w_small_exp, w_diff;
    logic [26:0] w_big_sig, w_small_sig, w_shifted, w_aligned;
    logic        w_lost;
    logic [1:0]  w_spec;

    assign w_a_zero = (r_acc[30:23] == 8'h00);
    assign w_b_zero = (r_op[30:23]  == 8'h00);
    assign w_a_inf  = (r_acc[30:23] == 8'hFF) && (r_acc[22:0] == 23'd0);
    assign w_b_inf  = (r_op[30:23]  == 8'hFF) && (r_op[22:0]  == 23'd0);
    assign w_a_nan  = (r_acc[30:23] == 8'hFF) && (r_acc[22:0] != 23'd0);
    assign w_b_nan  = (r_op[30:23]  == 8'hFF) && (r_op[22:0]  != 23'd0);

    // Exponent 0 means zero: the denormal fraction is dropped entirely.
    assign w_a_mag  = w_a_zero ? 31'd0 : r_acc[30:0];
    assign w_b_mag  = w_b_zero ? 31'd0 : r_op[30:0];
    assign w_a_sig  = w_a_zero ? 27'd0 : {1'b1, r_acc[22:0], 3'b000};
    assign w_b_sig  = w_b_zero ? 27'd0 : {1'b1, r_op[22:0],  3'b000};

    // Biased exponent/fraction order equals magnitude order for finite values.
    assign w_a_ge      = (w_a_mag >= w_b_mag);
    assign w_big_exp   = w_a_ge ? r_acc[30:23] : r_op[30:23];
    assign w_small_exp = w_a_ge ? r_op[30:23]  : r_acc[30:23];
    assign w_big_sig   = w_a_ge ? w_a_sig : w_b_sig;
    assign w_small_sig = w_a_ge ? w_b_sig : w_a_sig;
    assign w_diff      = w_big_exp - w_small_exp;

    // Bits shifted out of the field fold into the sticky (LSB) position.
    assign w_shifted = w_small_sig >> w_diff;
    assign w_lost    = ((w_shifted << w_diff) != w_small_sig);
    assign w_aligned = (w_diff >= 8'd27) ? {26'd0, |w_small_sig}
                                         : {w_shifted[26:1], w_shifted[0] | w_lost};

    assign w_spec = (r_nan || w_a_nan || w_b_nan ||
                     (w_a_inf && w_b_inf && (r_acc[31] != r_op[31]))) ? SP_NAN  :
                    (w_a_inf || w_b_inf)                              ? SP_PASS :
                                                                        SP_NONE;

    // ------------------------------------------------------------------------
    // NORM: leading-zero count, normalize, round, range check
    // ------------------------------------------------------------------------
    logic [4:0]  w_lzc;
    logic [26:0] w_mant27;
    logic [9:0]  w_exp_n;      // two's complement, may go below zero
    logic        w_rnd_up;
    logic [24:0] w_mant25;
    logic [22:0] w_frac;
    logic [9:0]  w_exp_r;
    logic [31:0] w_res;
    logic        w_res_ovf;

    // Priority encoder: the highest set bit is visited last and wins.
    always_comb begin
        w_lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) w_lzc = 5'(26 - i);
        end
    end

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave a value held and infer a latch.
    always_comb begin
        w_mant27  = r_sum[26:0] << w_lzc;
        w_exp_n   = {2'b00, r_exp} - {5'd0, w_lzc};
        if (r_sum[27]) begin
            w_mant27 = {r_sum[27:2], r_sum[1] | r_sum[0]};
            w_exp_n  = {2'b00, r_exp} + 10'd1;
        end

        // Nearest-even: round up when guard is set and anything below it,
        // or the kept LSB, is set.
        w_rnd_up  = ROUND_EN & w_mant27[2] & (w_mant27[1] | w_mant27[0] | w_mant27[3]);
        w_mant25  = {1'b0, w_mant27[26:3]} + {24'd0, w_rnd_up};
        w_frac    = w_mant25[24] ? w_mant25[23:1] : w_mant25[22:0];
        w_exp_r   = w_exp_n + {9'd0, w_mant25[24]};

        w_res     = 32'd0;
        w_res_ovf = 1'b0;
        case (r_spec)
            SP_NAN:  w_res = QNAN;
            SP_PASS: w_res = r_spec_val;
            default: begin
                if (r_sum == 28'd0) begin
                    w_res = 32'd0;
                end else if (!w_exp_r[9] && (w_exp_r >= 10'd255)) begin
                    w_res     = {r_sign, 8'hFF, 23'd0};
                    w_res_ovf = 1'b1;
                end else if (w_exp_r[9] || (w_exp_r == 10'd0)) begin
                    w_res = {r_sign, 31'd0};
                end else begin
                    w_res = {r_sign, w_exp_r[7:0], w_frac};
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= 32'd0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_nan      <= 1'b0;
            r_op       <= 32'd0;
            r_last     <= 1'b0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= 8'd0;
            r_big      <= 27'd0;
            r_small    <= 27'd0;
            r_spec     <= SP_NONE;
            r_spec_val <= 32'd0;
            r_sum      <= 28'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op   <= in_data;
                        r_last <= in_last;
                        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign     <= w_a_ge ? r_acc[31] : r_op[31];
                    r_sub      <= r_acc[31] ^ r_op[31];
                    r_exp      <= w_big_exp;
                    r_big      <= w_big_sig;
                    r_small    <= w_aligned;
                    r_spec     <= w_spec;
                    r_spec_val <= w_a_inf ? r_acc : r_op;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    // Larger magnitude first, so the difference never wraps.
                    r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                     : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_acc <= w_res;
                    if (w_res_ovf)        r_ovf <= 1'b1;
                    if (r_spec == SP_NAN) r_nan <= 1'b1;
                    r_state <= r_last ? S_OUT : S_IDLE;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc   <= 32'd0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_nan   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // State is IDLE throughout reset; gating with rst_n keeps in_ready low then.
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_acc;
    assign out_cnt   = r_cnt;
    assign out_ovf   = r_ovf;
    assign out_nan   = r_nan;

endmodule

// File: tb/tb_fp32_accum.sv
// -----------------------------------------------------------------------------
// tb_fp32_accum
//
// Self-checking bench for fp32_accum. A reference model sums each pair of
// operands exactly as wide integers in units of 2^-149, then rounds the exact
// result to 24 significant bits (truncation, or nearest-even when
// FP32_ACC_ROUND_EN is defined) and applies the flush/overflow/special rules.
// Directed sums cover the listed corner cases; random sums cover the rest.
// The counter width is reduced so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_fp32_accum;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int W       = 300;   // wide enough for any exact FP32 sum

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_nan;

    fp32_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [31:0] m_acc;
    bit          m_nan;
    bit          m_ovf;
    int          m_cnt;

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Magnitude in units of 2^-149; denormals count as zero.
    function automatic logic [W-1:0] mag(input logic [31:0] x);
        logic [W-1:0] v;
        if (x[30:23] == 8'h00) return '0;
        v = W'({1'b1, x[22:0]});
        return v << (int'(x[30:23]) - 1);
    endfunction

    task automatic model_add(input logic [31:0] op);
        logic [W-1:0] ma, mb, s, t;
        logic         sgn;
        logic [24:0]  sig;
        int           p, e;
        if (m_nan || is_nan(m_acc) || is_nan(op) ||
            (is_inf(m_acc) && is_inf(op) && (m_acc[31] != op[31]))) begin
            m_acc = 32'h7FC0_0000;
            m_nan = 1'b1;
        end else if (is_inf(m_acc)) begin
            m_acc = m_acc;
        end else if (is_inf(op)) begin
            m_acc = op;
        end else begin
            ma = mag(m_acc);
            mb = mag(op);
            if (m_acc[31] == op[31]) begin s = ma + mb; sgn = op[31]; end
            else if (ma >= mb)       begin s = ma - mb; sgn = m_acc[31]; end
            else                     begin s = mb - ma; sgn = op[31]; end
            if (s == '0) begin
                m_acc = 32'd0;
            end else begin
                p = 0;
                for (int i = 0; i < W; i++) if (s[i]) p = i;
                if (p < 23) begin
                    m_acc = {sgn, 31'd0};   // below the smallest normal
                end else begin
                    e   = p - 22;
                    t   = s >> (p - 23);
                    sig = t[24:0];
`ifdef FP32_ACC_ROUND_EN
                    begin
                        bit g, rest;
                        g    = (p >= 24) ? s[p-24] : 1'b0;
                        rest = (p >= 25) ? ((s & ((W'(1) << (p - 24)) - W'(1))) != '0) : 1'b0;
                        if (g && (rest || sig[0])) sig = sig + 25'd1;
                    end
`endif
                    if (sig[24]) begin sig = sig >> 1; e++; end
                    if (e >= 255) begin
                        m_acc = {sgn, 8'hFF, 23'd0};
                        m_ovf = 1'b1;
                    end else if (e <= 0) begin
                        m_acc = {sgn, 31'd0};
                    end else begin
                        m_acc = {sgn, 8'(e), sig[22:0]};
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_fp();
        int          k;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 99);
        s = 1'($urandom);
        f = 23'($urandom);
        if      (k < 4)  begin e = 8'h00; f = 23'd0; end
        else if (k < 8)  begin e = 8'h00; f = f | 23'd1; end
        else if (k < 10) begin e = 8'hFF; f = 23'd0; end
        else if (k < 12) begin e = 8'hFF; f = f | 23'd1; end
        else if (k < 18) e = 8'($urandom_range(248, 254));
        else if (k < 24) e = 8'($urandom_range(1, 6));
        else             e = 8'($urandom_range(110, 140));
        return {s, e, f};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake helpers
    // ------------------------------------------------------------------------
    task automatic send(input logic [31:0] d, input logic last, output int hs_cyc);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        hs_cyc   = cyc;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'b0;
    endtask

    // Sends one whole sum, checks the result against the model, optionally
    // stalls the output for `hold` cycles, then consumes it.
    task automatic run_sum(input string name, input logic [31:0] elems[$], input int hold,
                           input bit has_const, input logic [31:0] const_data);
        int hs, first_hs, budget, n;
        n = elems.size();
        m_acc = 32'd0; m_nan = 1'b0; m_ovf = 1'b0; m_cnt = 0;
        first_hs = 0;
        for (int i = 0; i < n; i++) begin
            model_add(elems[i]);
            if (m_cnt < CNT_MAX) m_cnt++;
            send(elems[i], (i == n - 1), hs);
            if (i == 0) first_hs = hs;
        end
        budget = 0;
        while (!out_valid && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        // Numbering the first handshake cycle as 1, out_valid is first high in
        // cycle 4*n+1: four cycles per element, plus the cycle after NORM.
        check({name, "_latency"}, 32'(cyc - first_hs + 2), 32'(4 * n + 1));
        check({name, "_data"}, out_data, m_acc);
        check({name, "_cnt"},  32'(out_cnt), 32'(m_cnt));
        check({name, "_ovf"},  32'(out_ovf), 32'(m_ovf));
        check({name, "_nan"},  32'(out_nan), 32'(m_nan));
        if (has_const) check({name, "_const"}, out_data, const_data);
        for (int k = 0; k < hold; k++) begin
            // Offer another element while stalled; it must not be taken.
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_data"},  out_data, m_acc);
            check({name, "_hold_cnt"},   32'(out_cnt), 32'(m_cnt));
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_consumed"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] q[$];
        int          hs;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_nan",   32'(out_nan),   32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        q = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};
        run_sum("basic", q, 0, 1'b1, 32'h4060_0000);

        q = '{32'h3F80_0000, 32'hBF80_0000};
        run_sum("cancel", q, 0, 1'b1, 32'h0000_0000);

        q = '{32'h7F7F_FFFF, 32'h7F7F_FFFF};
        run_sum("overflow", q, 0, 1'b1, 32'h7F80_0000);

        q = '{32'h7F80_0000, 32'hFF80_0000};
        run_sum("inf_minus_inf", q, 0, 1'b1, 32'h7FC0_0000);

        q = '{32'h7FC0_0001, 32'h3F80_0000};
        run_sum("nan_in", q, 0, 1'b1, 32'h7FC0_0000);

        q = '{32'hFF80_0000, 32'h3F80_0000};
        run_sum("inf_plus_fin", q, 0, 1'b1, 32'hFF80_0000);

        q = '{32'h0040_0000};
        run_sum("denorm_single", q, 0, 1'b1, 32'h0000_0000);

        q = '{32'hC120_0000};
        run_sum("single", q, 0, 1'b1, 32'hC120_0000);

        q = '{32'h3F80_0000, 32'h33C0_0000};
`ifdef FP32_ACC_ROUND_EN
        run_sum("round", q, 0, 1'b1, 32'h3F80_0001);
`else
        run_sum("round", q, 0, 1'b1, 32'h3F80_0000);
`endif

        q.delete();
        repeat (17) q.push_back(32'h3F80_0000);
        run_sum("cnt_sat", q, 0, 1'b1, 32'h4188_0000);

        q = '{32'h40A0_0000};
        run_sum("backpressure", q, 5, 1'b1, 32'h40A0_0000);

        // Reset in the ALIGN cycle of the second element of a new sum.
        send(32'h3F80_0000, 1'b0, hs);
        send(32'h4000_0000, 1'b0, hs);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  out_data,       32'd0);
        check("midrst_out_cnt",   32'(out_cnt),   32'd0);
        check("midrst_out_ovf",   32'(out_ovf),   32'd0);
        check("midrst_out_nan",   32'(out_nan),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_in_ready",  32'(in_ready),  32'd1);

        q = '{32'h4040_0000};
        run_sum("post_reset", q, 0, 1'b1, 32'h4040_0000);

        for (int r = 0; r < 40; r++) begin
            int n;
            q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) q.push_back(rand_fp());
            run_sum($sformatf("rnd%0d", r), q, $urandom_range(0, 3), 1'b0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time %0t expected finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp32_accum.md
Name: fp32_accum

Overview:
- Sequential FP32 accumulator that sits directly downstream of the combinational FP32 multiplier.
- Consumes a stream of single-precision products over a valid/ready handshake and sums them with a multi-cycle align/add/normalize FSM.
- Presents the final sum when the element tagged last has been added.
- Forms the reduction half of the dot-product datapath.

Parameters:
- CNT_W, 16, width of the saturating element counter reported with each result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept an element.
- in_data  input  32  IEEE-754 single-precision addend (product).
- in_last  input  1  marks final element of the current sum.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  accumulated FP32 sum.
- out_cnt  output  CNT_W  number of elements in this sum, saturating at all-ones.
- out_ovf  output  1  sum overflowed to infinity from finite operands.
- out_nan  output  1  result is NaN (NaN input, or inf + -inf).

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE; accumulator = +0 (0x00000000); count = 0; flags = 0.
  - in_ready = 0 while rst_n is low; out_valid = 0; out_data = 0; out_cnt = 0; out_ovf = 0; out_nan = 0.
- Reset mid-operation discards the partial sum and any pending result; no output handshake occurs.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_data and in_last, increment count (saturating), go to ALIGN.
  - ALIGN: unpack accumulator and operand. Exponent 0 is treated as zero (denormals flushed). Pick the larger-magnitude operand; right-shift the smaller 24-bit significand (hidden 1) by the exponent difference into a 27-bit field (3 guard/round/sticky bits). A shift of 27 or more leaves sticky only.
  - ADD: equal signs add, differing signs subtract smaller from larger; result sign = sign of larger magnitude. 28-bit datapath.
  - NORM:
    - Carry out: shift right 1, exponent + 1.
    - Otherwise shift left by the leading-zero count, in one cycle via a priority encoder.
    - Truncate to 23 fraction bits (see optional feature).
    - Exponent >= 255 → ±inf, set ovf.
    - Exponent <= 0 → ±0.
    - Exact cancellation → +0.
    - Write back to the accumulator. Captured last → OUT, else → IDLE.
  - OUT: out_valid = 1; out_data/out_cnt/flags held stable; in_ready = 0. On out_ready, clear accumulator/count/flags and go to IDLE.
- Latency:
  - Fixed 4 cycles per element, IDLE → ALIGN → ADD → NORM.
  - out_valid rises the cycle after NORM of the last element.
  - Throughput is one element per 4 cycles.
- Specials:
  - Any NaN input, or inf + opposite inf, makes the accumulator quiet NaN 0x7FC00000 and sets nan; it stays NaN until the result is consumed.
  - inf + finite = that inf.
  - out_ovf is not set by an infinite input.
- A single-element sum (in_last on the first element) returns that element, normalized (denormal → +0).
- in_data is sampled only on handshake; it is a don't-care otherwise.

Optional Feature:
- Macro FP32_ACC_ROUND_EN.
- Defined: NORM applies round-to-nearest-even using the guard/round/sticky bits.
  - A mantissa carry from rounding increments the exponent.
  - Rounding into exponent 255 yields inf and sets ovf.
- Undefined: truncation (round toward zero), matching the upstream multiplier.
- Latency is unchanged in both builds.

Test Plan:
- Basic sum: 0x3F800000, 0x40000000, 0x3F000000 (last) → out_data 0x40600000, out_cnt 3, ovf = 0, nan = 0; out_valid exactly 13 cycles after the first handshake.
- Cancellation: 0x3F800000, 0xBF800000 (last) → out_data 0x00000000.
- Overflow: 0x7F7FFFFF, 0x7F7FFFFF (last) → 0x7F800000, out_ovf = 1.
- Specials:
  - 0x7F800000, 0xFF800000 (last) → 0x7FC00000, out_nan = 1.
  - 0x7FC00001, 0x3F800000 (last) → 0x7FC00000.
- Rounding: 0x3F800000, 0x33C00000 (last) → 0x3F800000 without FP32_ACC_ROUND_EN, 0x3F800001 with it.
- Backpressure and reset:
  - Hold out_ready low 5 cycles → out_data/out_cnt stable, in_ready = 0.
  - Then assert rst_n low during ALIGN of a new sum → all outputs 0 immediately; the next sum 0x40400000 (last) → 0x40400000, out_cnt 1.
